spi_master: RTL and testbench
=============================

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter: DATA_WIDTH, 8, bits per transfer; legal range 2..32.
REQ-002 Parameter: CLK_DIV, 4, clk cycles per sck half-period; legal range 1..255.
REQ-003 Port: clk  input  1  system clock; all logic on posedge clk.
REQ-004 Port: rst  input  1  reset rst, synchronous, active-high.
REQ-005 Port: start  input  1  transfer request; sampled only in IDLE.
REQ-006 Port: data_in  input  DATA_WIDTH  word to transmit, MSB first; latched when start is accepted.
REQ-007 Port: mode  input  2  SPI mode {CPOL,CPHA}; latched when start is accepted.
REQ-008 Port: data_out  output  DATA_WIDTH  last received word.
REQ-009 Port: busy  output  1  high whenever state is not IDLE.
REQ-010 Port: done  output  1  one-cycle pulse at end of transfer.
REQ-011 Port: sck  output  1  serial clock, registered.
REQ-012 Port: cs_n  output  1  chip select, active-low, registered.
REQ-013 Port: mosi  output  1  serial data to the slave, registered.
REQ-014 Port: miso  input  1  serial data from the slave.

Function
REQ-015 The FSM SHALL have states IDLE, LEAD, XFER and TRAIL, and no others.
REQ-016 In IDLE with start=1, the block SHALL latch data_in and mode and enter LEAD on the next cycle (cycle T+1).
REQ-017 start asserted while busy=1 SHALL be ignored, with no effect on the current or any later transfer.
REQ-018 cs_n SHALL be low for all of LEAD, XFER and TRAIL, and high in IDLE.
REQ-019 LEAD SHALL last exactly CLK_DIV cycles.
REQ-020 XFER SHALL produce exactly 2*DATA_WIDTH sck toggles, spaced CLK_DIV cycles apart; the first toggle SHALL occur on entry to XFER.
REQ-021 TRAIL SHALL last exactly CLK_DIV cycles after the final toggle, then return to IDLE.
REQ-022 Total cs_n-low time SHALL be (2*DATA_WIDTH+2)*CLK_DIV cycles.
REQ-023 The idle level of sck SHALL equal the latched CPOL; in IDLE, sck SHALL load mode[1] every cycle.
REQ-024 CPHA=0: mosi SHALL present the MSB on LEAD entry, miso SHALL be sampled at each leading (odd) toggle, and the next bit SHALL be shifted out at each trailing toggle.
REQ-025 CPHA=1: the next bit SHALL be driven at each leading toggle, and miso SHALL be sampled at each trailing toggle.
REQ-026 miso SHALL be sampled in the same clk cycle as the sampling sck toggle; no synchronizer is required.
REQ-027 Received bits SHALL shift in LSB-ward, so the first bit sampled ends as data_out[DATA_WIDTH-1].
REQ-028 On the cycle of return to IDLE: done=1, data_out SHALL load the received word, and cs_n SHALL go high.
REQ-029 data_out SHALL hold its value until the next done pulse.
REQ-030 start=1 on the done cycle SHALL be accepted, so back-to-back transfers have exactly one cycle of cs_n high.
REQ-031 mosi SHALL be 0 while cs_n=1.
REQ-032 Changes on mode or data_in during a transfer SHALL have no effect on that transfer.
REQ-033 The half-period counter SHALL be $clog2(CLK_DIV+1) bits wide and the edge counter $clog2(2*DATA_WIDTH+1) bits wide, with no wrap during a transfer.

Reset
REQ-034 rst SHALL take priority over all other inputs, including in the middle of a transfer.
REQ-035 On rst, the block SHALL set state=IDLE, cs_n=1, sck=0, mosi=0, busy=0, done=0 and data_out=0, and clear the shift registers and counters.
REQ-036 A transfer aborted by rst SHALL NOT produce done, and data_out SHALL remain 0.

Structure
REQ-037 Package spi_pkg SHALL hold the state_t enum (IDLE, LEAD, XFER, TRAIL) and the mode constants MODE0..MODE3 plus the CPOL_BIT and CPHA_BIT indices, shared with spi_slave.
REQ-038 Sub-module spi_clk_gen SHALL contain the CLK_DIV counter, emitting a one-cycle tick per half-period and a lead/trail edge flag.
REQ-039 The FSM and the shift registers SHALL remain in spi_master.

Verification
REQ-040 Mode 0, CLK_DIV=4, data_in=0xA5, slave model returns 0x3C -> mosi bits 1,0,1,0,0,1,0,1 valid at rising sck; data_out=0x3C with done; cs_n low 72 cycles.
REQ-041 Mode 3, data_in=0x81, slave returns 0xFF -> sck idles high; mosi changes on falling edges; data_out=0xFF.
REQ-042 Mode 1 and mode 2, data_in=0x5A, loopback miso=mosi -> data_out=0x5A in both modes.
REQ-043 start pulsed mid-transfer with data_in=0x00 -> ignored; only one done; data_out equals the first transfer's received word.
REQ-044 rst asserted at edge 7 of a transfer -> next cycle cs_n=1, sck=0, busy=0; no done; data_out=0.
REQ-045 CLK_DIV=1, start held high across done -> two transfers with a 1-cycle cs_n-high gap; second data_out correct.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: controller states and mode encodings used by
// spi_master and spi_slave.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        XFER  = 2'd2,
        TRAIL = 2'd3
    } state_t;

    // Mode is {CPOL, CPHA}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    localparam int CPOL_BIT = 1;
    localparam int CPHA_BIT = 0;

endpackage

// File: rtl/spi_master_if.sv
// Bundle of the SPI master's request/response and serial-line signals.
interface spi_master_if #(
    parameter int DATA_WIDTH = 8
);

    // Handshake: start is a request honoured on any cycle busy is low
    // (including the done cycle); data_in and mode are captured with it.
    // done pulses for exactly one cycle with data_out valid, and data_out
    // then holds until the next done.
    logic                  start;
    logic [DATA_WIDTH-1:0] data_in;
    logic [1:0]            mode;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  busy;
    logic                  done;
    logic                  sck;
    logic                  cs_n;
    logic                  mosi;
    logic                  miso;

    modport master (
        input  start, data_in, mode, miso,
        output data_out, busy, done, sck, cs_n, mosi
    );

    modport slave (
        output start, data_in, mode, miso,
        input  data_out, busy, done, sck, cs_n, mosi
    );

endinterface

// File: rtl/spi_clk_gen.sv
// Half-period timer: ticks once every CLK_DIV cycles while enabled and
// tracks whether the next sck toggle is a leading or trailing edge.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic tick_o,
    output logic lead_o
);

    localparam int            CW   = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          lead_q, lead_d;

    always_comb begin
        tick_o = en_i && (cnt_q == LAST);
        cnt_d  = '0;
        lead_d = 1'b1;
        if (en_i) begin
            cnt_d  = tick_o ? '0 : cnt_q + 1'b1;
            lead_d = tick_o ? ~lead_q : lead_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            lead_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            lead_q <= lead_d;
        end
    end

    assign lead_o = lead_q;

endmodule

// File: rtl/spi_master.sv
// SPI master: one DATA_WIDTH-bit full-duplex transfer per accepted start,
// in any of the four CPOL/CPHA modes.
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4
) (
    input  logic         clk,
    input  logic         rst,
    spi_master_if.master bus,
    output state_t       state_o
);

    localparam int            EW        = $clog2(2 * DATA_WIDTH + 1);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_WIDTH);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [EW-1:0]         edge_q, edge_d;
    logic                  cpha_q, cpha_d;
    logic                  sck_q, sck_d;
    logic                  cs_n_q, cs_n_d;
    logic                  mosi_q, mosi_d;
    logic                  done_q, done_d;
    logic                  tick, lead_edge, toggle;

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk    (clk),
        .rst    (rst),
        .en_i   (state_q != IDLE),
        .tick_o (tick),
        .lead_o (lead_edge)
    );

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
        edge_d  = edge_q;
        cpha_d  = cpha_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        done_d  = 1'b0;
        toggle  = 1'b0;

        case (state_q)
            IDLE: begin
                sck_d  = bus.mode[CPOL_BIT];
                mosi_d = 1'b0;
                edge_d = '0;
                rx_d   = '0;
                if (bus.start) begin
                    state_d = LEAD;
                    cpha_d  = bus.mode[CPHA_BIT];
                    // tx holds the bits not yet on mosi; CPHA=0 presents the MSB now
                    if (bus.mode[CPHA_BIT]) begin
                        tx_d = bus.data_in;
                    end else begin
                        tx_d   = bus.data_in << 1;
                        mosi_d = bus.data_in[DATA_WIDTH-1];
                    end
                end
            end
            LEAD: begin
                if (tick) begin
                    state_d = XFER;
                    toggle  = 1'b1;
                end
            end
            XFER: begin
                if (tick) begin
                    if (edge_q == LAST_EDGE) state_d = TRAIL;
                    else                     toggle  = 1'b1;
                end
            end
            TRAIL: begin
                if (tick) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    dout_d  = rx_q;
                    mosi_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Sampling edge is leading for CPHA=0 and trailing for CPHA=1
        if (toggle) begin
            sck_d  = ~sck_q;
            edge_d = edge_q + 1'b1;
            if (lead_edge != cpha_q) begin
                rx_d = {rx_q[DATA_WIDTH-2:0], bus.miso};
            end else begin
                mosi_d = tx_q[DATA_WIDTH-1];
                tx_d   = tx_q << 1;
            end
        end

        cs_n_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            dout_q  <= '0;
            edge_q  <= '0;
            cpha_q  <= 1'b0;
            sck_q   <= 1'b0;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            edge_q  <= edge_d;
            cpha_q  <= cpha_d;
            sck_q   <= sck_d;
            cs_n_q  <= cs_n_d;
            mosi_q  <= mosi_d;
            done_q  <= done_d;
        end
    end

    assign bus.data_out = dout_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.sck      = sck_q;
    assign bus.cs_n     = cs_n_q;
    assign bus.mosi     = mosi_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a CLK_DIV=4 and a CLK_DIV=1 instance, each driven
// against a behavioural SPI slave that records the mosi word and line timing.
module tb_spi_master;
    import spi_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    spi_master_if #(.DATA_WIDTH(W)) bus0 ();
    spi_master_if #(.DATA_WIDTH(W)) bus1 ();
    state_t st0, st1;

    spi_master #(.DATA_WIDTH(W), .CLK_DIV(4)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.master), .state_o(st0));
    spi_master #(.DATA_WIDTH(W), .CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.master), .state_o(st1));

    // Per-channel drive and observation
    logic         drv_start[2] = '{1'b0, 1'b0};
    logic [W-1:0] drv_data[2]  = '{'0, '0};
    logic [1:0]   drv_mode[2]  = '{2'b00, 2'b00};
    logic         lb[2]        = '{1'b0, 1'b0};
    logic         miso_r[2]    = '{1'b0, 1'b0};

    assign bus0.start   = drv_start[0];
    assign bus0.data_in = drv_data[0];
    assign bus0.mode    = drv_mode[0];
    assign bus0.miso    = lb[0] ? bus0.mosi : miso_r[0];
    assign bus1.start   = drv_start[1];
    assign bus1.data_in = drv_data[1];
    assign bus1.mode    = drv_mode[1];
    assign bus1.miso    = lb[1] ? bus1.mosi : miso_r[1];

    logic sck_w[2], cs_w[2], mosi_w[2], done_w[2], busy_w[2];
    logic [W-1:0] dout_w[2];
    assign sck_w[0]  = bus0.sck;      assign sck_w[1]  = bus1.sck;
    assign cs_w[0]   = bus0.cs_n;     assign cs_w[1]   = bus1.cs_n;
    assign mosi_w[0] = bus0.mosi;     assign mosi_w[1] = bus1.mosi;
    assign done_w[0] = bus0.done;     assign done_w[1] = bus1.done;
    assign busy_w[0] = bus0.busy;     assign busy_w[1] = bus1.busy;
    assign dout_w[0] = bus0.data_out; assign dout_w[1] = bus1.data_out;

    // Slave model state
    logic [W-1:0] sw[2]       = '{'0, '0};
    logic [1:0]   cur_mode[2] = '{2'b00, 2'b00};
    logic [W-1:0] sw_l[2]     = '{'0, '0};
    logic [W-1:0] cap[2]      = '{'0, '0};
    logic         cpha_l[2]   = '{1'b0, 1'b0};
    logic         prev_sck[2] = '{1'b0, 1'b0};
    logic         prev_cs[2]  = '{1'b1, 1'b1};
    logic         prev_mosi[2] = '{1'b0, 1'b0};
    int edges[2]    = '{0, 0};
    int cs_low[2]   = '{0, 0};
    int sidx[2]     = '{0, 0};
    int glitch[2]   = '{0, 0};
    int hi_run[2]   = '{0, 0};
    int hi_last[2]  = '{0, 0};
    int done_cnt[2] = '{0, 0};

    // Slave samples mosi on the CPHA-selected edge and shifts miso on the other
    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (cs_w[c] === 1'b0) begin
                if (prev_cs[c]) begin
                    edges[c] = 0; cs_low[c] = 0; cap[c] = '0; sidx[c] = 0; glitch[c] = 0;
                    sw_l[c] = sw[c]; cpha_l[c] = cur_mode[c][0];
                    hi_last[c] = hi_run[c]; hi_run[c] = 0;
                    miso_r[c] = sw[c][W-1];
                end else if (sck_w[c] != prev_sck[c]) begin
                    edges[c]++;
                    if (edges[c][0] != cpha_l[c]) begin
                        cap[c] = {cap[c][W-2:0], mosi_w[c]};
                        if (mosi_w[c] != prev_mosi[c]) glitch[c]++;
                    end else if (cpha_l[c]) begin
                        if (sidx[c] < W) miso_r[c] = sw_l[c][W-1-sidx[c]];
                        sidx[c]++;
                    end else begin
                        sidx[c]++;
                        if (sidx[c] < W) miso_r[c] = sw_l[c][W-1-sidx[c]];
                    end
                end else if (mosi_w[c] != prev_mosi[c]) begin
                    glitch[c]++;
                end
                cs_low[c]++;
            end else begin
                hi_run[c]++;
            end
            if (done_w[c] === 1'b1) done_cnt[c]++;
            prev_sck[c]  = sck_w[c];
            prev_cs[c]   = cs_w[c];
            prev_mosi[c] = mosi_w[c];
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_xfer(input int c, input logic [W-1:0] d, input logic [1:0] m,
                              input logic [W-1:0] s, input logic l);
        drv_mode[c] = m; cur_mode[c] = m; sw[c] = s; lb[c] = l;
        tick();
        chk("idle_sck", 32'(sck_w[c]), 32'(m[1]));
        drv_data[c] = d; drv_start[c] = 1'b1;
        tick();
        drv_start[c] = 1'b0;
        chk("lead_csn", 32'(cs_w[c]), 0);
        chk("lead_busy", 32'(busy_w[c]), 1);
        chk("lead_mosi", 32'(mosi_w[c]), 32'(m[0] ? 1'b0 : d[W-1]));
    endtask

    task automatic finish_xfer(input int c, input logic [W-1:0] exp_rx, input logic [W-1:0] exp_tx);
        int n = 0;
        int d0 = done_cnt[c];
        while (done_w[c] !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        chk("done_seen", 32'(done_w[c]), 1);
        chk("data_out", 32'(dout_w[c]), 32'(exp_rx));
        chk("mosi_word", 32'(cap[c]), 32'(exp_tx));
        chk("sck_edges", edges[c], 2 * W);
        chk("cs_low_cycles", cs_low[c], (2 * W + 2) * (c == 1 ? 1 : 4));
        chk("mosi_stable", glitch[c], 0);
        chk("done_count", done_cnt[c] - d0, 1);
        chk("end_csn", 32'(cs_w[c]), 1);
        chk("end_mosi", 32'(mosi_w[c]), 0);
        chk("end_busy", 32'(busy_w[c]), 0);
        tick();
        chk("done_pulse", 32'(done_w[c]), 0);
        chk("data_hold", 32'(dout_w[c]), 32'(exp_rx));
    endtask

    initial begin
        logic [W-1:0] d, s, d2, s2;
        logic [1:0]   m;
        logic         l;
        int           c, dc, n;

        rst = 1'b1;
        repeat (3) tick();
        chk("rst_state0", 32'(st0), 32'(IDLE));
        chk("rst_state1", 32'(st1), 32'(IDLE));
        for (int k = 0; k < 2; k++) begin
            chk("rst_csn", 32'(cs_w[k]), 1);
            chk("rst_sck", 32'(sck_w[k]), 0);
            chk("rst_mosi", 32'(mosi_w[k]), 0);
            chk("rst_busy", 32'(busy_w[k]), 0);
            chk("rst_done", 32'(done_w[k]), 0);
            chk("rst_dout", 32'(dout_w[k]), 0);
        end
        rst = 1'b0;
        tick();

        // Mode 0 reference transfer
        start_xfer(0, 8'hA5, MODE0, 8'h3C, 1'b0);
        finish_xfer(0, 8'h3C, 8'hA5);

        // Mode 3: sck idles high, mosi only moves on falling edges
        start_xfer(0, 8'h81, MODE3, 8'hFF, 1'b0);
        finish_xfer(0, 8'hFF, 8'h81);
        chk("mode3_idle_sck", 32'(sck_w[0]), 1);

        // Loopback in modes 1 and 2
        start_xfer(0, 8'h5A, MODE1, 8'h00, 1'b1);
        finish_xfer(0, 8'h5A, 8'h5A);
        start_xfer(0, 8'h5A, MODE2, 8'h00, 1'b1);
        finish_xfer(0, 8'h5A, 8'h5A);

        // start pulsed while busy with different data and mode
        dc = done_cnt[0];
        start_xfer(0, 8'h3C, MODE0, 8'h96, 1'b0);
        repeat (20) tick();
        drv_data[0] = '0; drv_mode[0] = MODE3; drv_start[0] = 1'b1;
        tick();
        drv_start[0] = 1'b0;
        chk("ignored_start_busy", 32'(busy_w[0]), 1);
        finish_xfer(0, 8'h96, 8'h3C);
        repeat (100) tick();
        chk("single_done", done_cnt[0] - dc, 1);
        chk("idle_after_ignored", 32'(busy_w[0]), 0);
        chk("dout_after_ignored", 32'(dout_w[0]), 32'h96);

        // Randomised transfers on both dividers
        for (int i = 0; i < 10; i++) begin
            c = i % 2;
            m = 2'($urandom_range(0, 3));
            d = W'($urandom);
            s = W'($urandom);
            l = 1'($urandom_range(0, 1));
            start_xfer(c, d, m, s, l);
            finish_xfer(c, l ? d : s, d);
        end

        // CLK_DIV=1 back-to-back with start held across done
        d = W'($urandom); s = W'($urandom); d2 = W'($urandom); s2 = W'($urandom);
        drv_mode[1] = MODE0; cur_mode[1] = MODE0; sw[1] = s; lb[1] = 1'b0;
        tick();
        drv_data[1] = d; drv_start[1] = 1'b1;
        tick();
        tick();
        drv_data[1] = d2; sw[1] = s2;
        finish_xfer(1, s, d);
        drv_start[1] = 1'b0;
        finish_xfer(1, s2, d2);
        chk("b2b_gap", hi_last[1], 1);

        // Reset in the middle of a transfer
        dc = done_cnt[0];
        start_xfer(0, W'($urandom), MODE0, W'($urandom), 1'b0);
        n = 0;
        while (edges[0] < 7 && n < 500) begin
            tick();
            n++;
        end
        chk("edge7_reached", edges[0], 7);
        rst = 1'b1;
        tick();
        chk("abort_csn", 32'(cs_w[0]), 1);
        chk("abort_sck", 32'(sck_w[0]), 0);
        chk("abort_busy", 32'(busy_w[0]), 0);
        chk("abort_done", 32'(done_w[0]), 0);
        chk("abort_mosi", 32'(mosi_w[0]), 0);
        chk("abort_dout", 32'(dout_w[0]), 0);
        chk("abort_state", 32'(st0), 32'(IDLE));
        rst = 1'b0;
        repeat (80) tick();
        chk("abort_no_done", done_cnt[0] - dc, 0);
        chk("abort_dout_held", 32'(dout_w[0]), 0);
        chk("abort_idle", 32'(busy_w[0]), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
